// File: rtl/frame_config_loader.sv
// +----------------------------------------------------------------------------+
// | frame_config_loader                                                        |
// | Header-driven loader: writes N rows of frame data, then pulses one strobe. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module frame_config_loader #(
   parameter int FrameBitsPerRow = 32,
   parameter int MaxFramesPerCol = 20,
   parameter int NumRows         = 4
) (
   input  logic                                 CLK,
   input  logic                                 reset,
   input  logic [31:0]                          in_data,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
   output logic [MaxFramesPerCol-1:0]           FrameStrobe,
   output logic                                 busy,
   output logic                                 err,
   output logic [15:0]                          frames_done
);

   localparam int FIDX_W = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
   localparam int CNT_W  = $clog2(NumRows + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LOAD   = 2'd1;
   localparam logic [1:0] STROBE = 2'd2;

   localparam logic [7:0]                 c_SYNC       = 8'hFA;
   localparam logic [7:0]                 c_MAX_FRAMES = 8'(MaxFramesPerCol);
   localparam logic [7:0]                 c_NUM_ROWS   = 8'(NumRows);
   localparam logic [MaxFramesPerCol-1:0] c_STB_ONE    = MaxFramesPerCol'(1);

   logic [1:0]                           r_state;
   logic [1:0]                           w_state_nxt;
   logic [FIDX_W-1:0]                    r_frame_idx;
   logic [CNT_W-1:0]                     r_nrows;
   logic [CNT_W-1:0]                     r_row_cnt;
   logic [NumRows*FrameBitsPerRow-1:0]   r_frame_data;
   logic                                 r_err;
   logic [15:0]                          r_frames_done;

   logic                                 w_in_ready;
   logic                                 w_busy;
   logic [MaxFramesPerCol-1:0]           w_strobe;
   logic                                 w_xfer;
   logic                                 w_hdr_ok;
   logic                                 w_last;
   logic [FrameBitsPerRow-1:0]           w_word;

   generate
      if (FrameBitsPerRow <= 32) begin : g_word_narrow
         assign w_word = in_data[FrameBitsPerRow-1:0];
      end else begin : g_word_wide
         assign w_word = {{(FrameBitsPerRow-32){1'b0}}, in_data};
      end
   endgenerate

   assign w_xfer   = in_valid & w_in_ready;
   assign w_hdr_ok = (in_data[31:24] == c_SYNC) &&
                     (in_data[15:8] < c_MAX_FRAMES) &&
                     (in_data[7:0] != 8'd0) &&
                     (in_data[7:0] <= c_NUM_ROWS);
   assign w_last   = (r_row_cnt == (r_nrows - CNT_W'(1)));

   // State register
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_xfer && w_hdr_ok) begin
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (w_xfer && w_last) begin
               w_state_nxt = STROBE;
            end
         end
         STROBE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Output decode; the strobe comes straight from the registered state and index
   always_comb begin
      w_in_ready = 1'b0;
      w_busy     = 1'b1;
      w_strobe   = '0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b0;
         end
         LOAD: begin
            w_in_ready = 1'b1;
         end
         STROBE: begin
            w_strobe = c_STB_ONE << r_frame_idx;
         end
         default: begin
            w_busy = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_frame_idx   <= '0;
         r_nrows       <= '0;
         r_row_cnt     <= '0;
         r_frame_data  <= '0;
         r_err         <= 1'b0;
         r_frames_done <= 16'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_xfer) begin
                  if (w_hdr_ok) begin
                     r_frame_idx <= in_data[8 +: FIDX_W];
                     r_nrows     <= in_data[CNT_W-1:0];
                     r_row_cnt   <= '0;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (w_xfer) begin
                  for (int r = 0; r < NumRows; r++) begin
                     if (r_row_cnt == CNT_W'(r)) begin
                        r_frame_data[r*FrameBitsPerRow +: FrameBitsPerRow] <= w_word;
                     end
                  end
                  r_row_cnt <= r_row_cnt + CNT_W'(1);
               end
            end
            STROBE: begin
               r_frames_done <= r_frames_done + 16'd1;
            end
            default: begin
               r_row_cnt <= '0;
            end
         endcase
      end
   end

   assign in_ready    = w_in_ready;
   assign busy        = w_busy;
   assign FrameStrobe = w_strobe;
   assign FrameData   = r_frame_data;
   assign err         = r_err;
   assign frames_done = r_frames_done;

endmodule

`default_nettype wire

// File: tb/tb_frame_config_loader.sv
// +----------------------------------------------------------------------------+
// | tb_frame_config_loader                                                     |
// | Directed vector table plus hand sequences for reset, gaps and wrap.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_frame_config_loader;

   localparam int FBPR = 32;
   localparam int MAXF = 20;
   localparam int NR   = 4;
   localparam int FDW  = FBPR * NR;

   logic            CLK = 1'b0;
   logic            reset;
   logic [31:0]     in_data;
   logic            in_valid;
   logic            in_ready;
   logic [FDW-1:0]  FrameData;
   logic [MAXF-1:0] FrameStrobe;
   logic            busy;
   logic            err;
   logic [15:0]     frames_done;

   int n_checks = 0;
   int n_fail   = 0;

   frame_config_loader #(
      .FrameBitsPerRow(FBPR),
      .MaxFramesPerCol(MAXF),
      .NumRows        (NR)
   ) dut (
      .CLK        (CLK),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .FrameData  (FrameData),
      .FrameStrobe(FrameStrobe),
      .busy       (busy),
      .err        (err),
      .frames_done(frames_done)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic            v;
      logic [31:0]     d;
      logic            rdy;
      logic            bsy;
      logic [MAXF-1:0] stb;
      logic [15:0]     done;
      logic            er;
      logic            chk_fd;
      logic [FDW-1:0]  fd;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input logic [FDW-1:0] act, input logic [FDW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Gapless transfer; caller guarantees the loader is ready
   task automatic put(input logic [31:0] d);
      @(negedge CLK);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge CLK);
   endtask

   // Transfer with random valid gaps; garbage on in_data while valid is low
   task automatic put_rand(input logic [31:0] d);
      bit acc = 1'b0;
      int cyc = 0;
      while (!acc) begin
         @(negedge CLK);
         in_valid = 1'($urandom_range(0, 1));
         in_data  = in_valid ? d : $urandom;
         #1;
         acc = in_valid & in_ready;
         @(posedge CLK);
         cyc++;
         if (!acc && cyc > 200) begin
            chk("put_rand_timeout", 1, 0);
            acc = 1'b1;
         end
      end
   endtask

   logic [FDW-1:0]  exp_fd;
   logic [15:0]     exp_done;
   logic [31:0]     w;
   logic [MAXF-1:0] exp_stb;
   int              f;

   initial begin
      // Table: frame F=3 N=4, frame F=19 N=2, then three bad headers
      tbl[0]  = '{1'b1, 32'hFA00_0304, 1'b1, 1'b0, 20'h0,     16'd0, 1'b0, 1'b1, '0};
      tbl[1]  = '{1'b1, 32'h1111_1111, 1'b1, 1'b1, 20'h0,     16'd0, 1'b0, 1'b0, '0};
      tbl[2]  = '{1'b1, 32'h2222_2222, 1'b1, 1'b1, 20'h0,     16'd0, 1'b0, 1'b0, '0};
      tbl[3]  = '{1'b1, 32'h3333_3333, 1'b1, 1'b1, 20'h0,     16'd0, 1'b0, 1'b0, '0};
      tbl[4]  = '{1'b1, 32'h4444_4444, 1'b1, 1'b1, 20'h0,     16'd0, 1'b0, 1'b0, '0};
      tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 20'h8,     16'd0, 1'b0, 1'b1,
                  {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}};
      tbl[6]  = '{1'b0, 32'h0,         1'b1, 1'b0, 20'h0,     16'd1, 1'b0, 1'b1,
                  {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}};
      tbl[7]  = '{1'b1, 32'hFA00_1302, 1'b1, 1'b0, 20'h0,     16'd1, 1'b0, 1'b0, '0};
      tbl[8]  = '{1'b1, 32'hAAAA_AAAA, 1'b1, 1'b1, 20'h0,     16'd1, 1'b0, 1'b0, '0};
      tbl[9]  = '{1'b1, 32'hBBBB_BBBB, 1'b1, 1'b1, 20'h0,     16'd1, 1'b0, 1'b0, '0};
      tbl[10] = '{1'b1, 32'hFA00_0304, 1'b0, 1'b1, 20'h80000, 16'd1, 1'b0, 1'b1,
                  {32'h4444_4444, 32'h3333_3333, 32'hBBBB_BBBB, 32'hAAAA_AAAA}};
      tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 20'h0,     16'd2, 1'b0, 1'b0, '0};
      tbl[12] = '{1'b1, 32'hFB00_0001, 1'b1, 1'b0, 20'h0,     16'd2, 1'b0, 1'b0, '0};
      tbl[13] = '{1'b1, 32'hFA00_1401, 1'b1, 1'b0, 20'h0,     16'd2, 1'b1, 1'b0, '0};
      tbl[14] = '{1'b1, 32'hFA00_0000, 1'b1, 1'b0, 20'h0,     16'd2, 1'b1, 1'b0, '0};
      tbl[15] = '{1'b0, 32'h0,         1'b1, 1'b0, 20'h0,     16'd2, 1'b1, 1'b1,
                  {32'h4444_4444, 32'h3333_3333, 32'hBBBB_BBBB, 32'hAAAA_AAAA}};

      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      reset = 1'b0;
      #1;
      chk("rst_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_fd", FrameData, 0);
      chk("rst_strobe", FrameStrobe, 0);
      chk("rst_err", err, 0);
      chk("rst_done", frames_done, 0);
      @(posedge CLK);

      for (int i = 0; i < 16; i++) begin
         @(negedge CLK);
         in_valid = tbl[i].v;
         in_data  = tbl[i].d;
         #1;
         chk($sformatf("v%0d_ready", i), in_ready, tbl[i].rdy);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].bsy);
         chk($sformatf("v%0d_strobe", i), FrameStrobe, tbl[i].stb);
         chk($sformatf("v%0d_done", i), frames_done, tbl[i].done);
         chk($sformatf("v%0d_err", i), err, tbl[i].er);
         if (tbl[i].chk_fd) chk($sformatf("v%0d_fd", i), FrameData, tbl[i].fd);
         @(posedge CLK);
      end

      // Reset mid-frame, coinciding with a data transfer
      put(32'hFA00_0502);
      put(32'h5555_5555);
      @(negedge CLK);
      in_valid = 1'b1;
      in_data  = 32'h6666_6666;
      reset    = 1'b1;
      #1;
      chk("abort_pre_strobe", FrameStrobe, 0);
      @(posedge CLK);
      @(negedge CLK);
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("abort_fd", FrameData, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready", in_ready, 1);
      chk("abort_strobe", FrameStrobe, 0);
      chk("abort_err", err, 0);
      chk("abort_done", frames_done, 0);
      @(posedge CLK);
      @(negedge CLK);
      #1;
      chk("abort_strobe2", FrameStrobe, 0);

      put(32'hFA00_0101);
      put(32'h7777_7777);
      @(negedge CLK);
      in_valid = 1'b0;
      #1;
      chk("post_abort_strobe", FrameStrobe, 20'h2);
      chk("post_abort_fd", FrameData, {96'h0, 32'h7777_7777});
      @(posedge CLK);
      @(negedge CLK);
      #1;
      chk("post_abort_strobe_off", FrameStrobe, 0);
      chk("post_abort_done", frames_done, 1);
      exp_done = 16'd1;
      exp_fd   = {96'h0, 32'h7777_7777};

      // 100 four-row frames with random valid gaps
      for (int i = 0; i < 100; i++) begin
         f = i % MAXF;
         put_rand({8'hFA, 8'h00, 8'(f), 8'd4});
         for (int k = 0; k < 4; k++) begin
            w = $urandom;
            exp_fd[k*FBPR +: FBPR] = w;
            put_rand(w);
         end
         @(negedge CLK);
         in_valid = 1'b0;
         #1;
         exp_stb = MAXF'(1) << f;
         chk($sformatf("rnd%0d_strobe", i), FrameStrobe, exp_stb);
         chk($sformatf("rnd%0d_fd", i), FrameData, exp_fd);
         chk($sformatf("rnd%0d_ready", i), in_ready, 0);
         @(posedge CLK);
         @(negedge CLK);
         #1;
         chk($sformatf("rnd%0d_strobe_off", i), FrameStrobe, 0);
         exp_done = exp_done + 16'd1;
      end
      chk("rnd_done", frames_done, exp_done);
      chk("rnd_err", err, 0);

      // Counter wrap from FFFF
      @(negedge CLK);
      force dut.r_frames_done = 16'hFFFF;
      #1;
      release dut.r_frames_done;
      #1;
      chk("wrap_pre", frames_done, 16'hFFFF);
      put(32'hFA00_0201);
      put(32'h1234_5678);
      @(negedge CLK);
      in_valid = 1'b0;
      #1;
      chk("wrap_strobe", FrameStrobe, 20'h4);
      @(posedge CLK);
      @(negedge CLK);
      #1;
      chk("wrap_done", frames_done, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
